// File: rtl/iq_pair_sched_pkg.sv
// Shared types and default widths for the I/Q pair scheduler.
// Imported by iq_pair_scheduler; see that file for the IQ_PAIR_SCHED_STATS_EN option.
package iq_pair_sched_pkg;

   localparam int DEFAULT_DATA_WIDTH  = 32;
   localparam int DEFAULT_COUNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GET_I = 2'd1,
      GET_Q = 2'd2,
      PUSH  = 2'd3
   } state_t;

endpackage

// File: rtl/iq_stat_counter.sv
// Statistics counter with increment strobe; SATURATE=0 wraps, SATURATE=1 sticks at all-ones.
module iq_stat_counter #(
   parameter int COUNT_WIDTH = 16,
   parameter bit SATURATE    = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   inc,
   output logic [COUNT_WIDTH-1:0] count
);

   logic [COUNT_WIDTH-1:0] count_reg;
   logic [COUNT_WIDTH-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (inc && (!SATURATE || (count_reg != '1))) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/iq_pair_scheduler.sv
// Pops interleaved I,Q words from a show-ahead FIFO and writes each pair to the I and Q FIFOs together.
// Define IQ_PAIR_SCHED_STATS_EN to implement pair_count/stall_count; otherwise both read 0.
module iq_pair_scheduler
   import iq_pair_sched_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  in_dout,
   input  logic                   in_empty,
   output logic                   in_rd_en,
   output logic [DATA_WIDTH-1:0]  I_din,
   output logic                   I_wr_en,
   input  logic                   I_full,
   output logic [DATA_WIDTH-1:0]  Q_din,
   output logic                   Q_wr_en,
   input  logic                   Q_full,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] pair_count,
   output logic [COUNT_WIDTH-1:0] stall_count
);

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] i_reg, i_next;
   logic [DATA_WIDTH-1:0] q_reg, q_next;
   logic                  rd_en;
   logic                  wr_en;

   // flush overrides every strobe and returns to IDLE; held words are simply abandoned
   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      q_next     = q_reg;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (enable) state_next = GET_I;
            end
            GET_I: begin
               if (!enable) begin
                  state_next = IDLE;
               end else if (!in_empty) begin
                  rd_en      = 1'b1;
                  i_next     = in_dout;
                  state_next = GET_Q;
               end
            end
            GET_Q: begin
               if (!in_empty) begin
                  rd_en      = 1'b1;
                  q_next     = in_dout;
                  state_next = PUSH;
               end
            end
            PUSH: begin
               if (!I_full && !Q_full) begin
                  wr_en      = 1'b1;
                  state_next = enable ? GET_I : IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         i_reg     <= '0;
         q_reg     <= '0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         q_reg     <= q_next;
      end
   end

   assign in_rd_en = rd_en;
   assign I_wr_en  = wr_en;
   assign Q_wr_en  = wr_en;
   assign I_din    = i_reg;
   assign Q_din    = q_reg;
   assign busy     = (state_reg != IDLE);

`ifdef IQ_PAIR_SCHED_STATS_EN
   logic stall_hit;
   assign stall_hit = (state_reg == PUSH) && !flush && (I_full || Q_full);

   iq_stat_counter #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .SATURATE    (1'b0)
   ) u_pair_counter (
      .clock (clock),
      .reset (reset),
      .inc   (wr_en),
      .count (pair_count)
   );

   iq_stat_counter #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .SATURATE    (1'b1)
   ) u_stall_counter (
      .clock (clock),
      .reset (reset),
      .inc   (stall_hit),
      .count (stall_count)
   );
`else
   assign pair_count  = '0;
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_iq_pair_scheduler.sv
// Randomized and directed bench for iq_pair_scheduler against a pair-assembly model.
module tb_iq_pair_scheduler;

   localparam int DW = 32;
   localparam int CW = 4;
`ifdef IQ_PAIR_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          enable, flush;
   logic [DW-1:0] in_dout;
   logic          in_empty;
   logic          in_rd_en;
   logic [DW-1:0] I_din, Q_din;
   logic          I_wr_en, Q_wr_en;
   logic          I_full, Q_full;
   logic          busy;
   logic [CW-1:0] pair_count, stall_count;

   iq_pair_scheduler #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .flush(flush),
      .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
      .I_din(I_din), .I_wr_en(I_wr_en), .I_full(I_full),
      .Q_din(Q_din), .Q_wr_en(Q_wr_en), .Q_full(Q_full),
      .busy(busy), .pair_count(pair_count), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a pair under assembly is the list of words popped so far (0..2).
   bit            m_active = 1'b0;
   int            m_n = 0;
   logic [DW-1:0] m_i = '0, m_q = '0;
   logic [CW-1:0] m_pairs = '0, m_stalls = '0;
   logic [DW-1:0] log_i[$], log_q[$];
   int            log_cyc[$];
   int            ccnt = 0;
   bit            e_rd, e_wr;

   always @(negedge clock) begin
      ccnt++;
      if (!reset) begin
         chk("rst_rd", in_rd_en, 0);
         chk("rst_wr", {I_wr_en, Q_wr_en}, 0);
         chk("rst_busy", busy, 0);
         chk("rst_din", {I_din, Q_din}, 0);
         chk("rst_cnt", {pair_count, stall_count}, 0);
         m_active = 0; m_n = 0; m_i = '0; m_q = '0; m_pairs = '0; m_stalls = '0;
      end else begin
         e_rd = 0; e_wr = 0;
         chk("busy", busy, m_active);
         chk("I_din", I_din, m_i);
         chk("Q_din", Q_din, m_q);
         chk("pair_count", pair_count, STATS ? m_pairs : '0);
         chk("stall_count", stall_count, STATS ? m_stalls : '0);
         if (flush) begin
            m_active = 0; m_n = 0;
         end else if (!m_active) begin
            m_active = enable;
         end else if (m_n == 0) begin
            if (!enable) m_active = 0;
            else if (!in_empty) begin e_rd = 1; m_i = in_dout; m_n = 1; end
         end else if (m_n == 1) begin
            if (!in_empty) begin e_rd = 1; m_q = in_dout; m_n = 2; end
         end else begin
            if (!I_full && !Q_full) begin
               e_wr = 1;
               log_i.push_back(m_i); log_q.push_back(m_q); log_cyc.push_back(ccnt);
               m_pairs = m_pairs + 1'b1;
               m_n = 0;
               m_active = enable;
            end else if (m_stalls != '1) begin
               m_stalls = m_stalls + 1'b1;
            end
         end
         chk("in_rd_en", in_rd_en, e_rd);
         chk("I_wr_en", I_wr_en, e_wr);
         chk("Q_wr_en", Q_wr_en, e_wr);
      end
   end

   // Upstream show-ahead FIFO, owned by the stimulus process.
   logic [DW-1:0] src[$];
   bit            rd_seen;

   task automatic upd();
      in_empty = (src.size() == 0);
      in_dout  = (src.size() != 0) ? src[0] : '0;
   endtask

   task automatic push(input logic [DW-1:0] w);
      src.push_back(w);
      upd();
   endtask

   task automatic step();
      @(negedge clock);
      rd_seen = in_rd_en;
      @(posedge clock);
      #1;
      if (rd_seen && src.size() != 0) void'(src.pop_front());
      upd();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      src.delete();
      upd();
      enable = 0; flush = 0; I_full = 0; Q_full = 0;
      run(2);
      reset = 1'b1;
   endtask

   task automatic wait_words(input int n);
      int k;
      k = 0;
      while (!(m_active && m_n == n) && k < 50) begin step(); k++; end
      if (k >= 50) chk("wait_timeout", 1, 0);
   endtask

   int base;

   initial begin
      reset = 1'b0; enable = 0; flush = 0; I_full = 0; Q_full = 0;
      upd();
      #1;
      chk("async_rst_outputs", {in_rd_en, I_wr_en, Q_wr_en, busy}, 0);
      do_reset();

      // two pairs back to back, three cycles apart
      base = log_i.size();
      push(32'h11); push(32'h22); push(32'h33); push(32'h44);
      enable = 1;
      run(10);
      chk("t1_nwrites", log_i.size() - base, 2);
      if (log_i.size() >= base + 2) begin
         chk("t1_pair0", {log_i[base], log_q[base]}, {32'h11, 32'h22});
         chk("t1_pair1", {log_i[base+1], log_q[base+1]}, {32'h33, 32'h44});
         chk("t1_spacing", log_cyc[base+1] - log_cyc[base], 3);
      end
      chk("t1_pair_count", pair_count, STATS ? 2 : 0);

      // Q_full stall for five PUSH cycles
      do_reset();
      base = log_i.size();
      Q_full = 1; enable = 1;
      push(32'h55); push(32'h66);
      wait_words(2);
      run(5);
      chk("t2_no_write", log_i.size() - base, 0);
      chk("t2_stall_count", stall_count, STATS ? 5 : 0);
      Q_full = 0; enable = 0;
      step();
      chk("t2_written", log_i.size() - base, 1);
      if (log_i.size() > base) chk("t2_pair", {log_i[base], log_q[base]}, {32'h55, 32'h66});

      // partial pair dropped by flush
      do_reset();
      base = log_i.size();
      enable = 1;
      push(32'h0A); push(32'h0B); push(32'h0C);
      run(6);
      wait_words(1);
      chk("t3_busy_getq", busy, 1);
      chk("t3_src_drained", src.size(), 0);
      flush = 1; step(); flush = 0;
      push(32'h0D); push(32'h0E);
      run(8);
      chk("t3_nwrites", log_i.size() - base, 2);
      if (log_i.size() >= base + 2) begin
         chk("t3_pair0", {log_i[base], log_q[base]}, {32'h0A, 32'h0B});
         chk("t3_pair1", {log_i[base+1], log_q[base+1]}, {32'h0D, 32'h0E});
      end

      // enable dropped in GET_Q completes the pair; dropped in GET_I keeps the head word
      do_reset();
      base = log_i.size();
      enable = 1;
      push(32'hA1);
      wait_words(1);
      enable = 0;
      run(2);
      push(32'hA2);
      run(4);
      chk("t4_completed", log_i.size() - base, 1);
      chk("t4_idle", busy, 0);
      enable = 1;
      run(3);
      push(32'hB1); enable = 0;
      run(3);
      chk("t4_head_kept", src.size(), 1);
      chk("t4_head_word", in_dout, 32'hB1);
      chk("t4_idle2", busy, 0);

      // reset while PUSH could write
      do_reset();
      base = log_i.size();
      enable = 1;
      push(32'hC1); push(32'hC2);
      wait_words(2);
      reset = 1'b0;
      #1;
      chk("t5_rst_wr", {I_wr_en, Q_wr_en, in_rd_en, busy}, 0);
      chk("t5_rst_din", {I_din, Q_din}, 0);
      run(2);
      reset = 1'b1; enable = 0;
      run(2);
      chk("t5_no_write", log_i.size() - base, 0);

      // counter wrap and saturation at 4 bits
      do_reset();
      enable = 1;
      for (int k = 0; k < 34; k++) push(32'h100 + k);
      run(60);
      chk("t6_pair_wrap", pair_count, STATS ? 1 : 0);
      Q_full = 1;
      push(32'h200); push(32'h201);
      run(25);
      chk("t6_stall_sat", stall_count, STATS ? 15 : 0);
      Q_full = 0;
      run(5);

      // randomized traffic
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         enable = ($urandom_range(7) != 0);
         I_full = ($urandom_range(3) == 0);
         Q_full = ($urandom_range(3) == 0);
         flush  = ($urandom_range(49) == 0);
         if ($urandom_range(1) == 1 && src.size() < 8) push($urandom);
         step();
      end
      flush = 0;
      run(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
